ip_rx: RTL and testbench

Receive-side IPv4 layer sitting between the MAC receive stage and the UDP receive stage. It parses and checks the 20-byte IPv4 header of each frame payload and drops packets that fail the checks. For accepted packets it strips the header, realigns the payload so UDP header byte 0 lands on data[63:56], and forwards it with the length/protocol/source-IP sideband the UDP stage consumes. 64-bit AXI-Stream in and out, no backpressure.

---
 rtl/ip_rx.sv | 195 +++++++++++++++++++
 tb/tb_ip_rx.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ip_rx.sv
// ip_rx: IPv4 receive layer. Checks the 20-byte header, strips it and realigns the payload for the UDP stage.
// Define IP_HDR_CHECKSUM_EN to also drop packets whose header checksum does not verify.
module ip_rx #(
  parameter logic [31:0] P_LOCAL_IP = 32'hC0A8_0164,
  parameter logic [7:0]  P_PROTOCOL = 8'd17
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [31:0] i_dymanic_local_ip,
  input  logic        i_dymanic_local_valid,
  input  logic [63:0] s_axis_mac_data,
  input  logic [7:0]  s_axis_mac_keep,
  input  logic        s_axis_mac_last,
  input  logic        s_axis_mac_valid,
  output logic [63:0] m_axis_ip_data,
  output logic [55:0] m_axis_ip_user,
  output logic [7:0]  m_axis_ip_keep,
  output logic        m_axis_ip_last,
  output logic        m_axis_ip_valid
);

  typedef enum logic [2:0] {IDLE, HDR1, HDR2, PAYLOAD, FLUSH, DROP} state_t;

  state_t      state;
  logic [31:0] local_ip;
  logic [15:0] total_len;
  logic        hdr0_ok;
  logic [7:0]  protocol;
  logic [31:0] src_ip;
  logic [15:0] rem;        // payload bytes still owed downstream
  logic [31:0] prev_lo;    // low half of the previous beat, upper half of the next output beat
  logic [3:0]  flush_cnt;

  function automatic logic [7:0] lead_mask(input logic [3:0] n);
    logic [7:0] m;
    m = '0;
    for (int i = 0; i < 8; i++) if (4'(i) < n) m[7-i] = 1'b1;
    return m;
  endfunction

  logic [3:0]  in_bytes;
  logic [15:0] pay_len;
  logic [15:0] pay_beats;
  logic        dest_ok;
  logic        accept;
  logic        short_last;
  logic [3:0]  avail;
  logic [3:0]  end_cnt;
  logic [15:0] rem_next;
  logic [3:0]  tail_cnt;
  logic [3:0]  drop_cnt;
  logic        csum_ok;

`ifdef IP_HDR_CHECKSUM_EN
  logic [19:0] csum_acc;
  logic [19:0] csum_sum;
  logic [16:0] csum_f1;
  logic [15:0] csum_f2;

  function automatic logic [19:0] sum4(input logic [63:0] d);
    return 20'(d[63:48]) + 20'(d[47:32]) + 20'(d[31:16]) + 20'(d[15:0]);
  endfunction

  always_comb begin
    csum_sum = csum_acc + 20'(s_axis_mac_data[63:48]) + 20'(s_axis_mac_data[47:32]);
    csum_f1  = 17'(csum_sum[15:0]) + 17'(csum_sum[19:16]);
    csum_f2  = csum_f1[15:0] + 16'(csum_f1[16]);
    csum_ok  = (csum_f2 == 16'hFFFF);
  end
`else
  assign csum_ok = 1'b1;
`endif

  // NOTE: every signal gets a default at the top of the block, so no path leaves it unassigned (no latch).
  always_comb begin
    in_bytes = '0;
    for (int i = 0; i < 8; i++) in_bytes = in_bytes + {3'b0, s_axis_mac_keep[i]};
    pay_len    = total_len - 16'd20;
    pay_beats  = (pay_len + 16'd7) >> 3;
    dest_ok    = (s_axis_mac_data[63:32] == local_ip) || (s_axis_mac_data[63:32] == 32'hFFFF_FFFF);
    accept     = hdr0_ok && (protocol == P_PROTOCOL) && dest_ok && (total_len > 16'd20) && csum_ok;
    short_last = s_axis_mac_last && (in_bytes <= 4'd4);
    avail      = short_last ? 4'd4 + in_bytes : 4'd8;
    end_cnt    = (rem < {12'h0, avail}) ? rem[3:0] : avail;
    rem_next   = rem - 16'd8;
    tail_cnt   = (rem_next < {12'h0, in_bytes - 4'd4}) ? rem_next[3:0] : in_bytes - 4'd4;
    drop_cnt   = (rem < 16'd4) ? rem[3:0] : 4'd4;
  end

  // NOTE: all state is written with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      // A reset mid-frame must not parse the frame's remaining beats as a fresh header.
      state           <= (s_axis_mac_valid && !s_axis_mac_last) ? DROP : IDLE;
      local_ip        <= P_LOCAL_IP;
      total_len       <= '0;
      hdr0_ok         <= 1'b0;
      protocol        <= '0;
      src_ip          <= '0;
      rem             <= '0;
      prev_lo         <= '0;
      flush_cnt       <= '0;
`ifdef IP_HDR_CHECKSUM_EN
      csum_acc        <= '0;
`endif
      m_axis_ip_data  <= '0;
      m_axis_ip_user  <= '0;
      m_axis_ip_keep  <= 8'hFF;
      m_axis_ip_last  <= 1'b0;
      m_axis_ip_valid <= 1'b0;
    end else begin
      if (i_dymanic_local_valid) local_ip <= i_dymanic_local_ip;
      m_axis_ip_valid <= 1'b0;
      m_axis_ip_last  <= 1'b0;
      case (state)
        IDLE, FLUSH: begin
          if (state == FLUSH) begin
            m_axis_ip_data  <= {prev_lo, 32'h0};
            m_axis_ip_keep  <= lead_mask(flush_cnt);
            m_axis_ip_last  <= 1'b1;
            m_axis_ip_valid <= 1'b1;
          end
          if (s_axis_mac_valid) begin
            total_len <= s_axis_mac_data[47:32];
            hdr0_ok   <= (s_axis_mac_data[63:56] == 8'h45) && (s_axis_mac_data[13:0] == 14'h0);
`ifdef IP_HDR_CHECKSUM_EN
            csum_acc  <= sum4(s_axis_mac_data);
`endif
            state     <= s_axis_mac_last ? IDLE : HDR1;
          end else begin
            state <= IDLE;
          end
        end
        HDR1: begin
          protocol <= s_axis_mac_data[55:48];
          src_ip   <= s_axis_mac_data[31:0];
`ifdef IP_HDR_CHECKSUM_EN
          csum_acc <= csum_acc + sum4(s_axis_mac_data);
`endif
          state    <= (!s_axis_mac_valid || s_axis_mac_last) ? IDLE : HDR2;
        end
        HDR2: begin
          if (!s_axis_mac_valid || s_axis_mac_last) begin
            state <= IDLE;
          end else if (accept) begin
            m_axis_ip_user <= {pay_beats, protocol, src_ip};
            prev_lo        <= s_axis_mac_data[31:0];
            rem            <= pay_len;
            if (pay_len <= 16'd4) begin
              m_axis_ip_data  <= {s_axis_mac_data[31:0], 32'h0};
              m_axis_ip_keep  <= lead_mask(pay_len[3:0]);
              m_axis_ip_last  <= 1'b1;
              m_axis_ip_valid <= 1'b1;
              state           <= DROP;
            end else begin
              state <= PAYLOAD;
            end
          end else begin
            state <= DROP;
          end
        end
        PAYLOAD: begin
          m_axis_ip_valid <= 1'b1;
          if (!s_axis_mac_valid) begin
            // Valid vanished: the previous beat was the frame end with all eight bytes enabled.
            m_axis_ip_data <= {prev_lo, 32'h0};
            m_axis_ip_keep <= lead_mask(drop_cnt);
            m_axis_ip_last <= 1'b1;
            state          <= IDLE;
          end else begin
            m_axis_ip_data <= {prev_lo, s_axis_mac_data[63:32]};
            prev_lo        <= s_axis_mac_data[31:0];
            if (rem <= {12'h0, avail} || short_last) begin
              m_axis_ip_keep <= lead_mask(end_cnt);
              m_axis_ip_last <= 1'b1;
              state          <= s_axis_mac_last ? IDLE : DROP;
            end else begin
              m_axis_ip_keep <= 8'hFF;
              rem            <= rem_next;
              if (s_axis_mac_last) begin
                flush_cnt <= tail_cnt;
                state     <= FLUSH;
              end
            end
          end
        end
        DROP: begin
          if (!s_axis_mac_valid || s_axis_mac_last) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ip_rx.sv
// Self-checking bench for ip_rx: a byte-level model predicts each output beat into a scoreboard queue.
`timescale 1ns/1ps
module tb_ip_rx;

  localparam logic [31:0] LOCAL_IP = 32'hC0A8_0164;
  localparam logic [31:0] SRC_IP   = 32'h0A01_0203;

  typedef struct packed {
    logic [63:0] data;
    logic [55:0] user;
    logic [7:0]  keep;
    logic        last;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] dyn_ip;
  logic        dyn_valid;
  logic [63:0] mac_data;
  logic [7:0]  mac_keep;
  logic        mac_last;
  logic        mac_valid;
  logic [63:0] m_data;
  logic [55:0] m_user;
  logic [7:0]  m_keep;
  logic        m_last;
  logic        m_valid;

  beat_t      exp_q[$];
  logic [7:0] frame[$];
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  ip_rx dut (
    .i_clk                 (clk),
    .i_rst                 (rst),
    .i_dymanic_local_ip    (dyn_ip),
    .i_dymanic_local_valid (dyn_valid),
    .s_axis_mac_data       (mac_data),
    .s_axis_mac_keep       (mac_keep),
    .s_axis_mac_last       (mac_last),
    .s_axis_mac_valid      (mac_valid),
    .m_axis_ip_data        (m_data),
    .m_axis_ip_user        (m_user),
    .m_axis_ip_keep        (m_keep),
    .m_axis_ip_last        (m_last),
    .m_axis_ip_valid       (m_valid)
  );

  task automatic build_frame(input logic [7:0] vihl, input logic [15:0] tlen, input logic [15:0] frag,
                             input logic [7:0] proto, input logic [31:0] dst, input int flen,
                             input bit bad_csum);
    logic [19:0] s;
    logic [15:0] cs;
    frame.delete();
    frame.push_back(vihl);        frame.push_back(8'h00);
    frame.push_back(tlen[15:8]);  frame.push_back(tlen[7:0]);
    frame.push_back(8'h12);       frame.push_back(8'h34);
    frame.push_back(frag[15:8]);  frame.push_back(frag[7:0]);
    frame.push_back(8'd64);       frame.push_back(proto);
    frame.push_back(8'h00);       frame.push_back(8'h00);
    for (int i = 3; i >= 0; i--) frame.push_back(SRC_IP[8*i +: 8]);
    for (int i = 3; i >= 0; i--) frame.push_back(dst[8*i +: 8]);
    for (int i = 20; i < flen; i++) frame.push_back(8'(i * 13 + 5));
    s = '0;
    for (int i = 0; i < 20; i += 2) s = s + {4'h0, frame[i], frame[i+1]};
    s = 20'(s[15:0]) + 20'(s[19:16]);
    s = 20'(s[15:0]) + 20'(s[16]);
    cs = ~s[15:0];
    if (bad_csum) cs = cs ^ 16'h0101;
    frame[10] = cs[15:8];
    frame[11] = cs[7:0];
    while (frame.size() > flen) void'(frame.pop_back());
  endtask

  // Payload is min(L, bytes actually present after the header), packed 8 per beat.
  task automatic expect_pkt(input logic [15:0] tlen, input logic [7:0] proto);
    int    l, n;
    beat_t e;
    l = int'(tlen) - 20;
    n = (l < frame.size() - 20) ? l : frame.size() - 20;
    for (int o = 0; o < n; o += 8) begin
      e.data = '0;
      e.keep = '0;
      for (int i = 0; i < 8; i++)
        if (o + i < n) begin
          e.data[63-8*i -: 8] = frame[20+o+i];
          e.keep[7-i] = 1'b1;
        end
      e.user = {16'((l + 7) / 8), proto, SRC_IP};
      e.last = (o + 8 >= n);
      exp_q.push_back(e);
    end
  endtask

  task automatic drive_beat(input int b, input bit is_last);
    logic [63:0] d;
    logic [7:0]  k;
    d = '0;
    k = '0;
    for (int i = 0; i < 8; i++)
      if (b * 8 + i < frame.size()) begin
        d[63-8*i -: 8] = frame[b*8+i];
        k[7-i] = 1'b1;
      end
    mac_data = d; mac_keep = k; mac_last = is_last; mac_valid = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic send_frame(input bit with_last);
    int nb;
    nb = (frame.size() + 7) / 8;
    for (int b = 0; b < nb; b++) drive_beat(b, with_last && (b == nb - 1));
    mac_valid = 1'b0; mac_last = 1'b0; mac_data = '0; mac_keep = '0;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic scoreboard_monitor();
    beat_t       e;
    logic [63:0] bm;
    forever begin
      @(negedge clk);
      if (m_valid === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_beat got data=%h user=%h keep=%h last=%b, expected no beat",
                   m_data, m_user, m_keep, m_last);
        end else begin
          e = exp_q.pop_front();
          for (int i = 0; i < 8; i++) bm[63-8*i -: 8] = {8{e.keep[7-i]}};
          if (((m_data & bm) !== (e.data & bm)) || (m_user !== e.user) ||
              (m_keep !== e.keep) || (m_last !== e.last)) begin
            errors++;
            $display("FAIL beat got data=%h user=%h keep=%h last=%b expected data=%h user=%h keep=%h last=%b",
                     m_data & bm, m_user, m_keep, m_last, e.data & bm, e.user, e.keep, e.last);
          end
        end
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; dyn_valid = 1'b0; dyn_ip = '0;
    mac_valid = 1'b0; mac_last = 1'b0; mac_data = '0; mac_keep = '0;
    wait_cycles(3);
    checks++; if (m_data !== 64'h0)   begin errors++; $display("FAIL reset_data got=%h expected=0", m_data); end
    checks++; if (m_user !== 56'h0)   begin errors++; $display("FAIL reset_user got=%h expected=0", m_user); end
    checks++; if (m_keep !== 8'hFF)   begin errors++; $display("FAIL reset_keep got=%h expected=ff", m_keep); end
    checks++; if (m_last !== 1'b0)    begin errors++; $display("FAIL reset_last got=%b expected=0", m_last); end
    checks++; if (m_valid !== 1'b0)   begin errors++; $display("FAIL reset_valid got=%b expected=0", m_valid); end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    build_frame(8'h45, 16'd36, 16'h0, 8'd17, LOCAL_IP, 46, 1'b0);
    expect_pkt(16'd36, 8'd17);
    send_frame(1'b1);
    build_frame(8'h45, 16'd33, 16'h0, 8'd17, LOCAL_IP, 46, 1'b0);
    expect_pkt(16'd33, 8'd17);
    send_frame(1'b1);
    wait_cycles(6);
    checks++;
    if (exp_q.size() !== 0) begin errors++; $display("FAIL basic_drain pending=%0d expected=0", exp_q.size()); end
  endtask

  task automatic test_dest();
    build_frame(8'h45, 16'd36, 16'h0, 8'd17, 32'h0A00_0001, 46, 1'b0);
    send_frame(1'b1);
    build_frame(8'h45, 16'd40, 16'h0, 8'd17, 32'hFFFF_FFFF, 46, 1'b0);
    expect_pkt(16'd40, 8'd17);
    send_frame(1'b1);
    wait_cycles(6);
    checks++;
    if (exp_q.size() !== 0) begin errors++; $display("FAIL dest_drain pending=%0d expected=0", exp_q.size()); end
  endtask

  task automatic test_dyn_ip();
    dyn_ip = 32'h0A00_0001; dyn_valid = 1'b1;
    wait_cycles(1);
    dyn_valid = 1'b0;
    build_frame(8'h45, 16'd36, 16'h0, 8'd17, 32'h0A00_0001, 46, 1'b0);
    expect_pkt(16'd36, 8'd17);
    send_frame(1'b1);
    build_frame(8'h45, 16'd36, 16'h0, 8'd17, LOCAL_IP, 46, 1'b0);
    send_frame(1'b1);
    wait_cycles(6);
    checks++;
    if (exp_q.size() !== 0) begin errors++; $display("FAIL dyn_ip_drain pending=%0d expected=0", exp_q.size()); end
    dyn_ip = LOCAL_IP; dyn_valid = 1'b1;
    wait_cycles(1);
    dyn_valid = 1'b0;
  endtask

  task automatic test_bad_hdr();
    build_frame(8'h45, 16'd36, 16'h0, 8'd6, LOCAL_IP, 46, 1'b0);
    send_frame(1'b1);
    build_frame(8'h46, 16'd36, 16'h0, 8'd17, LOCAL_IP, 46, 1'b0);
    send_frame(1'b1);
    build_frame(8'h45, 16'd36, 16'h0001, 8'd17, LOCAL_IP, 46, 1'b0);
    send_frame(1'b1);
    build_frame(8'h45, 16'd20, 16'h0, 8'd17, LOCAL_IP, 46, 1'b0);
    send_frame(1'b1);
    wait_cycles(6);
    checks++;
    if (exp_q.size() !== 0) begin errors++; $display("FAIL bad_hdr_drain pending=%0d expected=0", exp_q.size()); end
  endtask

  task automatic test_checksum();
    build_frame(8'h45, 16'd36, 16'h0, 8'd17, LOCAL_IP, 46, 1'b1);
`ifndef IP_HDR_CHECKSUM_EN
    expect_pkt(16'd36, 8'd17);
`endif
    send_frame(1'b1);
    build_frame(8'h45, 16'd44, 16'h0, 8'd17, LOCAL_IP, 46, 1'b0);
    expect_pkt(16'd44, 8'd17);
    send_frame(1'b1);
    wait_cycles(6);
    checks++;
    if (exp_q.size() !== 0) begin errors++; $display("FAIL checksum_drain pending=%0d expected=0", exp_q.size()); end
  endtask

  task automatic test_truncated();
    build_frame(8'h45, 16'd60, 16'h0, 8'd17, LOCAL_IP, 42, 1'b0);
    expect_pkt(16'd60, 8'd17);
    send_frame(1'b1);
    wait_cycles(2);
    build_frame(8'h45, 16'd60, 16'h0, 8'd17, LOCAL_IP, 48, 1'b0);
    expect_pkt(16'd60, 8'd17);
    send_frame(1'b0);
    wait_cycles(6);
    checks++;
    if (exp_q.size() !== 0) begin errors++; $display("FAIL truncated_drain pending=%0d expected=0", exp_q.size()); end
  endtask

  task automatic test_back_to_back();
    build_frame(8'h45, 16'd60, 16'h0, 8'd17, LOCAL_IP, 45, 1'b0);
    expect_pkt(16'd60, 8'd17);
    send_frame(1'b1);
    build_frame(8'h45, 16'd36, 16'h0, 8'd17, LOCAL_IP, 46, 1'b0);
    expect_pkt(16'd36, 8'd17);
    send_frame(1'b1);
    build_frame(8'h45, 16'd36, 16'h0, 8'd17, LOCAL_IP, 8, 1'b0);
    send_frame(1'b1);
    build_frame(8'h45, 16'd23, 16'h0, 8'd17, LOCAL_IP, 46, 1'b0);
    expect_pkt(16'd23, 8'd17);
    send_frame(1'b1);
    wait_cycles(6);
    checks++;
    if (exp_q.size() !== 0) begin errors++; $display("FAIL b2b_drain pending=%0d expected=0", exp_q.size()); end
  endtask

  task automatic test_reset_mid();
    build_frame(8'h45, 16'd36, 16'h0, 8'd17, LOCAL_IP, 46, 1'b0);
    for (int b = 0; b < 3; b++) drive_beat(b, 1'b0);
    rst = 1'b1;
    drive_beat(3, 1'b0);
    rst = 1'b0;
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_valid got=%b expected=0", m_valid); end
    checks++; if (m_keep !== 8'hFF) begin errors++; $display("FAIL rst_mid_keep got=%h expected=ff", m_keep); end
    checks++; if (m_user !== 56'h0) begin errors++; $display("FAIL rst_mid_user got=%h expected=0", m_user); end
    drive_beat(4, 1'b0);
    drive_beat(5, 1'b1);
    mac_valid = 1'b0; mac_last = 1'b0;
    build_frame(8'h45, 16'd36, 16'h0, 8'd17, LOCAL_IP, 46, 1'b0);
    expect_pkt(16'd36, 8'd17);
    send_frame(1'b1);
    wait_cycles(6);
    checks++;
    if (exp_q.size() !== 0) begin errors++; $display("FAIL rst_mid_drain pending=%0d expected=0", exp_q.size()); end
  endtask

  initial begin
    fork
      scoreboard_monitor();
    join_none
    test_reset();
    test_basic();
    test_dest();
    test_dyn_ip();
    test_bad_hdr();
    test_checksum();
    test_truncated();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
